// File: rtl/signal_router_n.sv
// signal_router_n: N-channel signal generator and router.
// Each channel produces one bit (constant, passthrough, divided clock or PWM) and steers it
// to any output pin; pins OR together every channel aimed at them. Configuration is written
// through a ready/valid-style strobe into shadow registers that commit at period boundaries.
// Optional macro SIGNAL_ROUTER_SYNC_EN adds 2-flop synchronisers on the passthrough inputs.
module signal_router_n #(
    parameter int unsigned NCH  = 8,
    parameter int unsigned DIVW = 8,
    parameter int unsigned PWMW = 8,
    localparam int unsigned LOCW = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  in,
    input  logic            cfg_we,
    output logic            cfg_ready,
    input  logic [LOCW-1:0] cfg_addr,
    input  logic [1:0]      cfg_sel,
    input  logic [LOCW-1:0] cfg_loc,
    input  logic            cfg_const,
    input  logic [DIVW-1:0] cfg_div,
    input  logic [PWMW-1:0] cfg_duty,
    output logic [NCH-1:0]  pending,
    output logic [NCH-1:0]  out
);

    localparam int unsigned NADDR = 1 << LOCW;

    typedef enum logic [1:0] {
        ModeConst = 2'd0,
        ModePass  = 2'd1,
        ModeDiv   = 2'd2,
        ModePwm   = 2'd3
    } mode_e;

    logic [NCH-1:0]   in_use;
    logic [NCH-1:0]   gen;
    logic [LOCW-1:0]  loc [NCH];
    logic [NCH-1:0]   route;
    logic [NADDR-1:0] pend_ext;

`ifdef SIGNAL_ROUTER_SYNC_EN
    logic [NCH-1:0] sync1_q, sync2_q;

    // Two-stage synchroniser for asynchronous board inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
        end
    end

    assign in_use = sync2_q;
`else
    assign in_use = in;
`endif

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        mode_e           sel_q, sel_d;
        logic            const_q, const_d;
        logic [DIVW-1:0] div_q, div_d;
        logic [PWMW-1:0] duty_q, duty_d;
        logic [LOCW-1:0] loc_q, loc_d;
        logic            sh_const_q, sh_const_d;
        logic [DIVW-1:0] sh_div_q, sh_div_d;
        logic [PWMW-1:0] sh_duty_q, sh_duty_d;
        logic            pend_q, pend_d;
        logic [DIVW-1:0] cnt_q, cnt_d;
        logic [PWMW-1:0] pwm_q, pwm_d;
        logic            tog_q, tog_d;
        logic            accept, terminal, wrap, commit, g;
        mode_e           new_sel;

        assign new_sel  = mode_e'(cfg_sel);
        assign accept   = cfg_we && (cfg_addr == LOCW'(ch)) && !pend_q;
        assign terminal = (cnt_q == div_q);
        assign wrap     = terminal && (pwm_q == {PWMW{1'b1}});
        // Deferred values land exactly on the boundary of the running waveform
        assign commit   = pend_q && (((sel_q == ModeDiv) && terminal) ||
                                     ((sel_q == ModePwm) && wrap));

        // Next-state: counters, deferred commit and configuration writes
        always_comb begin
            sel_d      = sel_q;
            const_d    = const_q;
            div_d      = div_q;
            duty_d     = duty_q;
            loc_d      = loc_q;
            sh_const_d = sh_const_q;
            sh_div_d   = sh_div_q;
            sh_duty_d  = sh_duty_q;
            pend_d     = pend_q;
            cnt_d      = cnt_q;
            pwm_d      = pwm_q;
            tog_d      = tog_q;

            case (sel_q)
                ModeDiv: begin
                    if (terminal) begin
                        cnt_d = '0;
                        tog_d = ~tog_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ModePwm: begin
                    if (terminal) begin
                        cnt_d = '0;
                        pwm_d = pwm_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase

            if (commit) begin
                const_d = sh_const_q;
                div_d   = sh_div_q;
                duty_d  = sh_duty_q;
                pend_d  = 1'b0;
            end

            // accept implies !pend_q, so it never coincides with commit
            if (accept) begin
                sh_const_d = cfg_const;
                sh_div_d   = cfg_div;
                sh_duty_d  = cfg_duty;
                loc_d      = cfg_loc;
                if (((sel_q == ModeDiv) || (sel_q == ModePwm)) && (new_sel == sel_q)) begin
                    pend_d = 1'b1;
                end else begin
                    sel_d   = new_sel;
                    const_d = cfg_const;
                    div_d   = cfg_div;
                    duty_d  = cfg_duty;
                    if (new_sel != sel_q) begin
                        cnt_d = '0;
                        pwm_d = '0;
                        tog_d = 1'b0;
                    end
                end
            end
        end

        // Channel state registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sel_q      <= ModeConst;
                const_q    <= 1'b0;
                div_q      <= '0;
                duty_q     <= '0;
                loc_q      <= LOCW'(ch);
                sh_const_q <= 1'b0;
                sh_div_q   <= '0;
                sh_duty_q  <= '0;
                pend_q     <= 1'b0;
                cnt_q      <= '0;
                pwm_q      <= '0;
                tog_q      <= 1'b0;
            end else begin
                sel_q      <= sel_d;
                const_q    <= const_d;
                div_q      <= div_d;
                duty_q     <= duty_d;
                loc_q      <= loc_d;
                sh_const_q <= sh_const_d;
                sh_div_q   <= sh_div_d;
                sh_duty_q  <= sh_duty_d;
                pend_q     <= pend_d;
                cnt_q      <= cnt_d;
                pwm_q      <= pwm_d;
                tog_q      <= tog_d;
            end
        end

        // Generated bit for the active mode
        always_comb begin
            g = 1'b0;
            case (sel_q)
                ModeConst: g = const_q;
                ModePass:  g = in_use[ch];
                ModeDiv:   g = tog_q;
                ModePwm:   g = (pwm_q < duty_q);
                default:   g = 1'b0;
            endcase
        end

        assign gen[ch]     = g;
        assign loc[ch]     = loc_q;
        assign pending[ch] = pend_q;
    end

    // Crossbar: each pin ORs every channel whose location matches it
    always_comb begin
        route = '0;
        for (int k = 0; k < NCH; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if (gen[c] && (loc[c] == LOCW'(k))) begin
                    route[k] = 1'b1;
                end
            end
        end
    end

    // Handshake: a channel with a pending commit refuses further writes
    always_comb begin
        pend_ext               = '0;
        pend_ext[NCH-1:0]      = pending;
        cfg_ready              = ~pend_ext[cfg_addr];
    end

    // Registered output pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= route;
        end
    end

endmodule
